// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot ring priority pointer and per-grant quantum cap.
// Latency: req to gnt 1 cycle; one IDLE bubble between consecutive grants.
// Backpressure: en=0 blocks new grants only; an active grant runs to req drop or quantum.
// Optional: define RR_SEED_LOAD_EN to add seed_ld/seed/seed_err pointer seeding.
module rr_ring_arbiter #(
  parameter int N       = 4,
  parameter int QUANTUM = 8,
  parameter int IDW     = $clog2(N),
  parameter int CW      = (QUANTUM > 1) ? $clog2(QUANTUM) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N-1:0]   req,
`ifdef RR_SEED_LOAD_EN
  input  logic           seed_ld,
  input  logic [N-1:0]   seed,
  output logic           seed_err,
`endif
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic [N-1:0]   ptr,
  output logic [CW-1:0]  hold_cnt
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] ptr_id;
  logic [IDW-1:0] win_id;
  logic           win_found;
  logic           hold_last;
  logic           release_now;

  // Encode the one-hot pointer into the index where the scan starts.
  always_comb begin
    ptr_id = '0;
    for (int i = 0; i < N; i++) begin
      if (ptr[i]) ptr_id = IDW'(i);
    end
  end

  // Scan requests upward from the pointer, wrapping at N-1; first hit wins.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_id) + k;
      if (idx >= N) idx = idx - N;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  // Grant ends when the owner drops its request or has used its full quantum.
  always_comb begin
    hold_last   = (hold_cnt == CW'(QUANTUM - 1));
    release_now = !req[gnt_id] || hold_last;
  end

`ifdef RR_SEED_LOAD_EN
  logic seed_onehot;

  // A valid seed has exactly one bit set.
  always_comb begin
    seed_onehot = (seed != '0) && ((seed & (seed - 1'b1)) == '0);
  end

  // Flag a bad seed load attempted in IDLE for a single cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seed_err <= 1'b0;
    else        seed_err <= (state == IDLE) && seed_ld && !seed_onehot;
  end
`endif

  // Arbitration FSM: issue grant from IDLE, hold or release in GRANT, rotate ptr on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      hold_cnt  <= '0;
      ptr       <= {{(N-1){1'b0}}, 1'b1};
    end else begin
      case (state)
        IDLE: begin
          if (en && win_found) begin
            state     <= GRANT;
            gnt       <= {{(N-1){1'b0}}, 1'b1} << win_id;
            gnt_valid <= 1'b1;
            gnt_id    <= win_id;
            hold_cnt  <= '0;
          end
`ifdef RR_SEED_LOAD_EN
          // Seeding takes effect next edge; this cycle's scan used the old ptr.
          if (seed_ld && seed_onehot) ptr <= seed;
`endif
        end
        default: begin
          if (release_now) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            hold_cnt  <= '0;
            ptr       <= {gnt[N-2:0], gnt[N-1]};
          end else begin
            hold_cnt  <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Directed bench for rr_ring_arbiter (N=4, QUANTUM=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Seed tests compile in only when RR_SEED_LOAD_EN is defined.
module tb_rr_ring_arbiter;

  localparam int N = 4;
  localparam int Q = 4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic [3:0] ptr;
  logic [1:0] hold_cnt;
`ifdef RR_SEED_LOAD_EN
  logic       seed_ld;
  logic [3:0] seed;
  logic       seed_err;
`endif

  int chk_cnt;
  int pass_cnt;

  rr_ring_arbiter #(.N(N), .QUANTUM(Q)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .req(req),
`ifdef RR_SEED_LOAD_EN
    .seed_ld(seed_ld),
    .seed(seed),
    .seed_err(seed_err),
`endif
    .gnt(gnt),
    .gnt_valid(gnt_valid),
    .gnt_id(gnt_id),
    .ptr(ptr),
    .hold_cnt(hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    en = 1'b1; req = 4'b0110;
    tick();
    chk_cnt++; if (gnt !== 4'b0010 || gnt_id !== 2'd1 || gnt_valid !== 1'b1)
      $display("FAIL basic_first: gnt=%b id=%0d vld=%b want 0010/1/1", gnt, gnt_id, gnt_valid);
    else pass_cnt++;
    req = 4'b0100;
    tick();
    chk_cnt++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || ptr !== 4'b0100)
      $display("FAIL basic_release: gnt=%b vld=%b ptr=%b want 0000/0/0100", gnt, gnt_valid, ptr);
    else pass_cnt++;
    tick();
    chk_cnt++; if (gnt !== 4'b0100 || gnt_id !== 2'd2)
      $display("FAIL basic_second: gnt=%b id=%0d want 0100/2", gnt, gnt_id);
    else pass_cnt++;
    req = 4'b0000;
    tick();
    chk_cnt++; if (gnt !== 4'b0000 || ptr !== 4'b1000 || gnt_id !== 2'd0)
      $display("FAIL basic_end: gnt=%b ptr=%b id=%0d want 0000/1000/0", gnt, ptr, gnt_id);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    req = 4'b1111;
    tick();
    tick();
    chk_cnt++; if (gnt !== 4'b1000 || hold_cnt !== 2'd1)
      $display("FAIL reset_pre: gnt=%b hold=%0d want 1000/1", gnt, hold_cnt);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0)
      $display("FAIL reset_async_gnt: gnt=%b vld=%b id=%0d want 0000/0/0", gnt, gnt_valid, gnt_id);
    else pass_cnt++;
    chk_cnt++; if (ptr !== 4'b0001 || hold_cnt !== 2'd0)
      $display("FAIL reset_async_ptr: ptr=%b hold=%0d want 0001/0", ptr, hold_cnt);
    else pass_cnt++;
    req = 4'b0000; en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_cnt++; if (gnt !== 4'b0000 || ptr !== 4'b0001)
      $display("FAIL reset_after: gnt=%b ptr=%b want 0000/0001", gnt, ptr);
    else pass_cnt++;
  endtask

  task automatic test_quantum();
    logic [3:0] exp_gnt;
    en = 1'b1; req = 4'b1111;
    for (int c = 0; c < 21; c++) begin
      tick();
      exp_gnt = ((c % 5) < 4) ? (4'b0001 << ((c / 5) % 4)) : 4'b0000;
      chk_cnt++; if (gnt !== exp_gnt)
        $display("FAIL quantum_gnt[%0d]: gnt=%b want %b", c, gnt, exp_gnt);
      else pass_cnt++;
      if ((c % 5) < 4) begin
        chk_cnt++; if (hold_cnt !== 2'(c % 5))
          $display("FAIL quantum_hold[%0d]: hold=%0d want %0d", c, hold_cnt, c % 5);
        else pass_cnt++;
      end
    end
    req = 4'b0000;
    tick();
    chk_cnt++; if (gnt !== 4'b0000 || ptr !== 4'b0010)
      $display("FAIL quantum_end: gnt=%b ptr=%b want 0000/0010", gnt, ptr);
    else pass_cnt++;
  endtask

  task automatic test_enable();
    req = 4'b1111;
    tick();
    chk_cnt++; if (gnt !== 4'b0010)
      $display("FAIL enable_start: gnt=%b want 0010", gnt);
    else pass_cnt++;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt++; if (gnt !== 4'b0010)
        $display("FAIL enable_hold[%0d]: gnt=%b want 0010", i, gnt);
      else pass_cnt++;
    end
    tick();
    chk_cnt++; if (gnt !== 4'b0000 || ptr !== 4'b0100)
      $display("FAIL enable_release: gnt=%b ptr=%b want 0000/0100", gnt, ptr);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt++; if (gnt !== 4'b0000 || ptr !== 4'b0100)
        $display("FAIL enable_blocked[%0d]: gnt=%b ptr=%b want 0000/0100", i, gnt, ptr);
      else pass_cnt++;
    end
    en = 1'b1;
    tick();
    chk_cnt++; if (gnt !== 4'b0100 || gnt_id !== 2'd2)
      $display("FAIL enable_resume: gnt=%b id=%0d want 0100/2", gnt, gnt_id);
    else pass_cnt++;
  endtask

  task automatic test_idle_hold();
    req = 4'b0000;
    tick();
    chk_cnt++; if (gnt !== 4'b0000 || ptr !== 4'b1000)
      $display("FAIL idle_enter: gnt=%b ptr=%b want 0000/1000", gnt, ptr);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_cnt++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || ptr !== 4'b1000)
        $display("FAIL idle_hold[%0d]: gnt=%b vld=%b ptr=%b want 0000/0/1000", i, gnt, gnt_valid, ptr);
      else pass_cnt++;
    end
  endtask

`ifdef RR_SEED_LOAD_EN
  task automatic test_seed();
    seed_ld = 1'b1; seed = 4'b0010;
    tick();
    chk_cnt++; if (ptr !== 4'b0010 || seed_err !== 1'b0)
      $display("FAIL seed_load1: ptr=%b err=%b want 0010/0", ptr, seed_err);
    else pass_cnt++;
    seed = 4'b1000;
    tick();
    chk_cnt++; if (ptr !== 4'b1000)
      $display("FAIL seed_load2: ptr=%b want 1000", ptr);
    else pass_cnt++;
    seed_ld = 1'b0; req = 4'b1001;
    tick();
    chk_cnt++; if (gnt !== 4'b1000 || gnt_id !== 2'd3)
      $display("FAIL seed_grant: gnt=%b id=%0d want 1000/3", gnt, gnt_id);
    else pass_cnt++;
    req = 4'b0000;
    tick();
    chk_cnt++; if (gnt !== 4'b0000 || ptr !== 4'b0001)
      $display("FAIL seed_release: gnt=%b ptr=%b want 0000/0001", gnt, ptr);
    else pass_cnt++;
    seed_ld = 1'b1; seed = 4'b0110;
    tick();
    chk_cnt++; if (seed_err !== 1'b1 || ptr !== 4'b0001)
      $display("FAIL seed_bad: err=%b ptr=%b want 1/0001", seed_err, ptr);
    else pass_cnt++;
    seed_ld = 1'b0;
    tick();
    chk_cnt++; if (seed_err !== 1'b0 || ptr !== 4'b0001)
      $display("FAIL seed_err_pulse: err=%b ptr=%b want 0/0001", seed_err, ptr);
    else pass_cnt++;
  endtask
`endif

  initial begin
    chk_cnt = 0; pass_cnt = 0;
    rst_n = 1'b0; en = 1'b0; req = 4'b0000;
`ifdef RR_SEED_LOAD_EN
    seed_ld = 1'b0; seed = 4'b0000;
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_reset();
    test_quantum();
    test_enable();
    test_idle_hold();
`ifdef RR_SEED_LOAD_EN
    test_seed();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/rr_ring_arbiter.md
Name: rr_ring_arbiter

Overview:
- Round-robin arbiter: shares one resource among N requesters.
- Priority pointer is a one-hot ring register that rotates left on every grant hand-off, the same structure as the team's ring counter.
- Issues a registered one-hot grant and caps each grant at a fixed quantum of cycles.
- Sits between requesting masters and a shared datapath; the resource sees only gnt and gnt_id.

Parameters:
- N, 4, number of requesters (N >= 2).
- QUANTUM, 8, maximum consecutive cycles one grant may be held (QUANTUM >= 1).
- IDW, $clog2(N), width of gnt_id.
- CW, $clog2(QUANTUM), width of hold_cnt (minimum 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable; 0 blocks new grants only.
- req  input  N  request vector, level-sensitive, bit i = requester i.
- gnt  output  N  one-hot grant, registered.
- gnt_valid  output  1  OR of gnt, registered.
- gnt_id  output  IDW  binary index of the granted requester; 0 when gnt_valid=0.
- ptr  output  N  current one-hot priority pointer.
- hold_cnt  output  CW  cycles the current grant has been held, minus 1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, hold_cnt=0, ptr={0..01}. Takes effect immediately, including mid-grant.
- States: IDLE, GRANT.
- IDLE to GRANT:
  - Condition: en=1 and |req.
  - Winner: first set req bit scanning from the ptr position upward (inclusive), wrapping from bit N-1 to bit 0.
  - Next edge: gnt=onehot(winner), gnt_id=winner, hold_cnt=0.
  - Latency req to gnt: 1 cycle.
- GRANT, every cycle:
  - If req[owner]=0, or hold_cnt==QUANTUM-1: next edge gnt=0, ptr=rotate-left(gnt) (owner+1, N-1 wraps to 0), state=IDLE.
  - Otherwise hold_cnt increments by 1 and the grant is unchanged.
- Grant length:
  - gnt stays high for the cycle in which the owner drops req; the release is seen 1 cycle late.
  - Maximum grant length is exactly QUANTUM cycles.
- Hand-off: there is always exactly one IDLE bubble cycle (gnt=0) between consecutive grants.
- req changes on non-owner bits during GRANT are ignored until IDLE.
- en=0:
  - During GRANT: the current grant continues to normal termination.
  - In IDLE: no grant is issued and ptr holds.
- ptr changes only on GRANT exit (and on seed load, if compiled in), so it is always one-hot.
- gnt is always zero or one-hot.
- No request in IDLE: stay in IDLE; ptr and outputs hold.
- QUANTUM=1: every grant lasts 1 cycle, followed by 1 bubble.

Optional Feature:
- Macro: RR_SEED_LOAD_EN.
- Defined:
  - Adds ports seed_ld (input, 1), seed (input, N) and seed_err (output, 1, registered, reset 0).
  - In IDLE with seed_ld=1 and seed one-hot: ptr<=seed on the next edge. That same cycle's arbitration still uses the old ptr.
  - seed_ld with a non-one-hot seed (zero or multi-bit): ptr unchanged, seed_err pulses 1 cycle.
  - seed_ld during GRANT: ignored, no error.
- Undefined: these ports are absent and ptr moves only through arbitration.

Test Plan:
- Reset: drive rst_n=0 mid-simulation with req=1111 -> gnt=0000, gnt_valid=0, gnt_id=0, ptr=0001 immediately, without waiting for a clock edge.
- Basic grant (N=4, ptr=0001, en=1, req=0110): next edge gnt=0010, gnt_id=1. Drop req[1] -> 1 edge later gnt=0000 and ptr=0100; next edge gnt=0100, gnt_id=2.
- Quantum (QUANTUM=4, req=1111 held constant): gnt=0001 for 4 cycles, 1 bubble, 0010 for 4, bubble, 0100, bubble, 1000, bubble, then 0001 again (wrap); no grant exceeds 4 cycles.
- Enable: en=0 asserted while gnt=0010 -> grant runs to req drop or quantum, then gnt=0 and stays 0 with ptr=0100 while en=0. Reassert en with req=1111 -> gnt=0100.
- Idle hold: req=0000 for 10 cycles after a grant -> gnt=0, state IDLE, ptr constant.
- RR_SEED_LOAD_EN:
  - In IDLE with seed_ld=1, seed=1000 -> ptr=1000. Then req=1001 -> gnt=1000.
  - Then seed=0110 with seed_ld=1 -> ptr unchanged, seed_err=1 for exactly 1 cycle.
